camera_config_seq: RTL

CAMERA_CONFIG_SEQ -- requirements
Module: camera_config_seq

---
 rtl/cam_cfg_pkg.sv | 26 ++
 rtl/sccb_master.sv | 117 +++++++++++
 rtl/camera_config_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared constants, sequencer state type and counter sizing helper for the
// camera register loader.
package cam_cfg_pkg;

    localparam logic [15:0] ROM_END    = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY  = 16'hFFF0;
    localparam logic [7:0]  SCCB_WR_ID = 8'h42;
    localparam int unsigned MIN_CNT_W  = 18;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        WRITE,
        DELAY,
        NEXT,
        DONE
    } cfg_state_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w > MIN_CNT_W) ? w : MIN_CNT_W;
    endfunction

endpackage

// File: rtl/sccb_master.sv
// SCCB 3-phase write engine: start, id/reg/value bytes each with a released
// 9th bit, stop, then an idle gap before the one-cycle done pulse.
module sccb_master
    import cam_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 25_000_000,
    parameter int unsigned SCCB_FREQ = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] id,
    input  logic [7:0] reg_addr,
    input  logic [7:0] value,
    output logic       sioc,
    output logic       siod_oe,
    output logic       done
);

    localparam int unsigned Q_RAW = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int unsigned Q     = (Q_RAW == 0) ? 1 : Q_RAW;
    localparam int unsigned CW    = cnt_width(Q);
    localparam logic [CW-1:0] Q_LAST = CW'(Q - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_GAP} sccb_state_e;

    sccb_state_e   r_state;
    logic [CW-1:0] r_qcnt;
    logic [1:0]    r_phase;
    logic [4:0]    r_bit;
    logic [26:0]   r_shift;
    logic          w_qtick;

    assign w_qtick = (r_qcnt == Q_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_qcnt  <= '0;
            r_phase <= 2'd0;
            r_bit   <= 5'd0;
            r_shift <= '0;
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_qcnt <= w_qtick ? '0 : r_qcnt + 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (req) begin
                        // Ack slots are 1 so the bus is released during them.
                        r_shift <= {id, 1'b1, reg_addr, 1'b1, value, 1'b1};
                        r_qcnt  <= '0;
                        siod_oe <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_qtick) begin
                        sioc    <= 1'b0;
                        r_phase <= 2'd0;
                        r_bit   <= 5'd0;
                        r_state <= S_BITS;
                    end
                end
                S_BITS: begin
                    if (w_qtick) begin
                        r_phase <= r_phase + 2'd1;
                        case (r_phase)
                            2'd0: siod_oe <= ~r_shift[26];
                            2'd1: sioc <= 1'b1;
                            2'd3: begin
                                sioc    <= 1'b0;
                                r_shift <= r_shift << 1;
                                if (r_bit == 5'd26) begin
                                    r_state <= S_STOP;
                                end else begin
                                    r_bit <= r_bit + 5'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_STOP: begin
                    if (w_qtick) begin
                        r_phase <= r_phase + 2'd1;
                        case (r_phase)
                            2'd0: siod_oe <= 1'b1;
                            2'd1: sioc <= 1'b1;
                            2'd2: begin
                                siod_oe <= 1'b0;
                                r_phase <= 2'd0;
                                r_state <= S_GAP;
                            end
                            default: ;
                        endcase
                    end
                end
                S_GAP: begin
                    if (w_qtick) begin
                        r_phase <= r_phase + 2'd1;
                        if (r_phase == 2'd3) begin
                            done    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/camera_config_seq.sv
// Walks a register/value ROM and issues one SCCB write per entry, honouring
// delay and end-of-table markers.
module camera_config_seq
    import cam_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 25_000_000,
    parameter int unsigned SCCB_FREQ    = 100_000,
    parameter int unsigned DELAY_CYCLES = 250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sioc,
    output logic        siod_oe,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW = cnt_width(DELAY_CYCLES);
    localparam logic [CW-1:0] DELAY_LAST = CW'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);

    cfg_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_data;
    logic          r_req;
    logic          w_wr_done;

    sccb_master #(
        .CLK_FREQ  (CLK_FREQ),
        .SCCB_FREQ (SCCB_FREQ)
    ) u_sccb (
        .clk      (clk),
        .rst      (rst),
        .req      (r_req),
        .id       (SCCB_WR_ID),
        .reg_addr (r_data[15:8]),
        .value    (r_data[7:0]),
        .sioc     (sioc),
        .siod_oe  (siod_oe),
        .done     (w_wr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_data   <= '0;
            r_req    <= 1'b0;
            rom_addr <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        rom_addr <= 8'd0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= FETCH;
                    end
                end
                FETCH: begin
                    // ROM is registered: data is valid in the second cycle.
                    if (r_cnt == CW'(1)) begin
                        r_data  <= rom_data;
                        r_cnt   <= '0;
                        r_state <= DECODE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    if (r_data == ROM_END) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else if (r_data == ROM_DELAY) begin
                        r_cnt   <= '0;
                        r_state <= DELAY;
                    end else begin
                        r_req   <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_req <= 1'b0;
                    if (w_wr_done) begin
                        r_state <= NEXT;
                    end
                end
                DELAY: begin
                    if (r_cnt == DELAY_LAST) begin
                        r_cnt   <= '0;
                        r_state <= NEXT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (rom_addr == 8'hFF) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        rom_addr <= rom_addr + 8'd1;
                        r_cnt    <= '0;
                        r_state  <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
